// File: rtl/song_sequencer.sv
// Song-position sequencer and hit judge for the Guitar Hero datapath.
// Define SONG_LOOP_EN to wrap the song back to position 0 instead of stopping in DONE.
module song_sequencer #(
    parameter int unsigned TICKS_PER_STEP = 25_000_000,
    parameter int unsigned SONG_LEN       = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic [4:0] songD,
    input  logic       button_in,
    input  logic       note_match,
    output logic [6:0] songDataPos,
    output logic       step_strobe,
    output logic       playing,
    output logic       song_done,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [6:0] streak
);

    localparam int unsigned TimerW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TICKS_PER_STEP - 1);
    localparam logic [TimerW-1:0] WindowOpen = TimerW'(2);
    localparam logic [6:0] PosLast = 7'(SONG_LEN - 1);
    localparam logic [6:0] StreakMax = 7'd127;

    typedef enum logic [1:0] {StIdle, StPlay, StPaused, StDone} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [6:0]        pos_q, pos_d;
    logic [6:0]        streak_q, streak_d;
    logic              hit_seen_q, hit_seen_d;
    logic              rest_press_q, rest_press_d;
    logic              strobe_q, strobe_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;

    logic in_window, terminal, note_on, hit_now, rest_now;

    // Timer values 0..1 cover the ROM settle after a position change.
    assign in_window = (timer_q >= WindowOpen);
    assign terminal  = (timer_q == TimerLast);
    assign note_on   = (songD != 5'd0);
    assign hit_now   = in_window && button_in && note_match && note_on && !hit_seen_q;
    assign rest_now  = in_window && button_in && !note_on;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pos_d        = pos_q;
        streak_d     = streak_q;
        hit_seen_d   = hit_seen_q;
        rest_press_d = rest_press_q;
        strobe_d     = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;

        if (start) begin
            state_d      = StPlay;
            timer_d      = '0;
            pos_d        = '0;
            streak_d     = '0;
            hit_seen_d   = 1'b0;
            rest_press_d = 1'b0;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (hit_now) begin
                        hit_d      = 1'b1;
                        hit_seen_d = 1'b1;
                        if (streak_q != StreakMax) begin
                            streak_d = streak_q + 7'd1;
                        end
                    end
                    if (rest_now) begin
                        rest_press_d = 1'b1;
                    end
                    // Pause is registered: this cycle still counts, freezing starts next cycle.
                    if (pause) begin
                        state_d = StPaused;
                    end
                    if (terminal) begin
                        timer_d      = '0;
                        hit_seen_d   = 1'b0;
                        rest_press_d = 1'b0;
                        if (!(hit_seen_q || hit_now) && (note_on || rest_press_q || rest_now)) begin
                            miss_d   = 1'b1;
                            streak_d = '0;
                        end
                        if (pos_q == PosLast) begin
`ifdef SONG_LOOP_EN
                            pos_d    = '0;
                            strobe_d = 1'b1;
`else
                            state_d  = StDone;
`endif
                        end else begin
                            pos_d    = pos_q + 7'd1;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                StPaused: begin
                    if (!pause) begin
                        state_d = StPlay;
                    end
                end
                default: begin
                end
            endcase
        end

        playing_d = (state_d == StPlay) || (state_d == StPaused);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            pos_q        <= '0;
            streak_q     <= '0;
            hit_seen_q   <= 1'b0;
            rest_press_q <= 1'b0;
            strobe_q     <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pos_q        <= pos_d;
            streak_q     <= streak_d;
            hit_seen_q   <= hit_seen_d;
            rest_press_q <= rest_press_d;
            strobe_q     <= strobe_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
        end
    end

    assign songDataPos = pos_q;
    assign step_strobe = strobe_q;
    assign playing     = playing_q;
    assign song_done   = done_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign streak      = streak_q;

endmodule
